// File: rtl/cpu_run_sequencer_if.sv
// Bus between the run controller and its surroundings.
// Control side: Go, ProgMask, Abort (batch launch/cancel) and CpuAck (CPU
// completion) flow into the sequencer; CpuReset/CpuStart/ProgSel drive the
// CPU, Busy/Done report batch status and Result* carry per-program results.
// The sequencer itself uses the slave modport; whoever drives it uses master.
interface cpu_run_sequencer_if #(
  parameter int NUM_PROGS = 4,
  parameter int CYC_W     = 16
);
  localparam int PSEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic                 Go;
  logic [NUM_PROGS-1:0] ProgMask;
  logic                 Abort;
  logic                 CpuAck;
  logic                 CpuReset;
  logic                 CpuStart;
  logic [PSEL_W-1:0]    ProgSel;
  logic                 Busy;
  logic                 Done;
  logic                 ResultValid;
  logic [PSEL_W-1:0]    ResultProg;
  logic [CYC_W-1:0]     ResultCycles;
  logic                 ResultTimeout;

  modport master (
    output Go, ProgMask, Abort, CpuAck,
    input  CpuReset, CpuStart, ProgSel, Busy, Done,
           ResultValid, ResultProg, ResultCycles, ResultTimeout
  );

  modport slave (
    input  Go, ProgMask, Abort, CpuAck,
    output CpuReset, CpuStart, ProgSel, Busy, Done,
           ResultValid, ResultProg, ResultCycles, ResultTimeout
  );
endinterface

// File: rtl/cpu_run_sequencer.sv
// Run controller for the CPU core. Launches each program selected in a
// latched mask with a reset+start / start-only sequence, waits for CpuAck in
// RUN (or a watchdog timeout), and reports cycles-to-completion per program.
// Ports: Clk, Reset (async, active-high) and the slave side of
// cpu_run_sequencer_if. Every output is registered.
module cpu_run_sequencer #(
  parameter int NUM_PROGS    = 4,
  parameter int CYC_W        = 16,
  parameter int INIT_CYCLES  = 2,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1000
) (
  input logic                Clk,
  input logic                Reset,
  cpu_run_sequencer_if.slave bus
);
  localparam int PSEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_START, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [NUM_PROGS-1:0] mask_q, mask_d;
  logic [CYC_W-1:0]     cnt_q, cnt_d;
  logic [PSEL_W-1:0]    prog_sel_q, prog_sel_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 cpu_start_q, cpu_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 res_valid_q, res_valid_d;
  logic [PSEL_W-1:0]    res_prog_q, res_prog_d;
  logic [CYC_W-1:0]     res_cycles_q, res_cycles_d;
  logic                 res_timeout_q, res_timeout_d;

  logic [PSEL_W:0]      first_hit;
  logic [PSEL_W:0]      next_hit;
  logic [CYC_W-1:0]     run_n;

  // Lowest set bit of m at index >= from; MSB of the result flags a hit.
  function automatic logic [PSEL_W:0] find_next(input logic [NUM_PROGS-1:0] m,
                                                 input int from);
    logic [PSEL_W:0] r;
    r = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, PSEL_W'(i)};
    end
    return r;
  endfunction

  assign first_hit = find_next(bus.ProgMask, 0);
  assign next_hit  = find_next(mask_q, int'(prog_sel_q) + 1);
  // cnt_q holds completed RUN cycles, so the current cycle number is cnt_q+1.
  assign run_n     = cnt_q + CYC_W'(1);

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    prog_sel_d    = prog_sel_q;
    done_d        = 1'b0;
    res_valid_d   = 1'b0;
    res_prog_d    = res_prog_q;
    res_cycles_d  = res_cycles_q;
    res_timeout_d = res_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Go) begin
          if (|bus.ProgMask) begin
            mask_d     = bus.ProgMask;
            prog_sel_d = first_hit[PSEL_W-1:0];
            cnt_d      = '0;
            state_d    = S_INIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_INIT: begin
        if (bus.Abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CYC_W'(INIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      S_START: begin
        if (bus.Abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CYC_W'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      S_RUN: begin
        // Abort wins over both Ack and the watchdog in the same cycle.
        if (bus.Abort) begin
          state_d = S_IDLE;
        end else if (bus.CpuAck || (run_n == CYC_W'(TIMEOUT))) begin
          res_valid_d   = 1'b1;
          res_prog_d    = prog_sel_q;
          res_cycles_d  = run_n;
          res_timeout_d = !bus.CpuAck;
          cnt_d         = '0;
          if (next_hit[PSEL_W]) begin
            prog_sel_d = next_hit[PSEL_W-1:0];
            state_d    = S_INIT;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = run_n;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin levels follow the state being entered so they are registered.
    cpu_reset_d = (state_d == S_IDLE) || (state_d == S_INIT);
    cpu_start_d = (state_d == S_INIT) || (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      cnt_q         <= '0;
      prog_sel_q    <= '0;
      cpu_reset_q   <= 1'b1;
      cpu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_prog_q    <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      prog_sel_q    <= prog_sel_d;
      cpu_reset_q   <= cpu_reset_d;
      cpu_start_q   <= cpu_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_valid_q   <= res_valid_d;
      res_prog_q    <= res_prog_d;
      res_cycles_q  <= res_cycles_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign bus.CpuReset      = cpu_reset_q;
  assign bus.CpuStart      = cpu_start_q;
  assign bus.ProgSel       = prog_sel_q;
  assign bus.Busy          = busy_q;
  assign bus.Done          = done_q;
  assign bus.ResultValid   = res_valid_q;
  assign bus.ResultProg    = res_prog_q;
  assign bus.ResultCycles  = res_cycles_q;
  assign bus.ResultTimeout = res_timeout_q;
endmodule

// File: tb/tb_cpu_run_sequencer.sv
module tb_cpu_run_sequencer;
  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;
  int done_only = 0;

  typedef struct {
    int prog;
    int cycles;
    bit tmo;
    bit done;
  } exp_t;

  exp_t sb[$];

  cpu_run_sequencer_if #(.NUM_PROGS(4), .CYC_W(16)) bus ();

  cpu_run_sequencer #(
    .NUM_PROGS(4), .CYC_W(16), .INIT_CYCLES(2), .START_CYCLES(2), .TIMEOUT(100)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result monitor: every ResultValid pops one expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ResultValid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result prog=%0d cycles=%0d required=no result",
                   bus.ResultProg, bus.ResultCycles);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.ResultProg !== 2'(e.prog) || bus.ResultCycles !== 16'(e.cycles) ||
              bus.ResultTimeout !== e.tmo || bus.Done !== e.done) begin
            bad++;
            $display("FAIL result got prog=%0d cyc=%0d tmo=%0b done=%0b required prog=%0d cyc=%0d tmo=%0b done=%0b",
                     bus.ResultProg, bus.ResultCycles, bus.ResultTimeout, bus.Done,
                     e.prog, e.cycles, e.tmo, e.done);
          end
        end
      end else if (bus.Done === 1'b1) begin
        total++;
        if (done_only > 0) done_only--;
        else begin
          bad++;
          $display("FAIL unexpected_done got Done=1 required Done=0");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got still running required finished");
    $fatal(1, "bench timeout");
  end

  task automatic go(input logic [3:0] m);
    bus.ProgMask = m;
    bus.Go = 1'b1;
    @(negedge clk);
    bus.Go = 1'b0;
  endtask

  // Returns at the negedge inside RUN cycle 1.
  task automatic wait_run_start();
    int n = 0;
    while (bus.CpuStart === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.CpuStart !== 1'b0) begin
      bad++;
      $display("FAIL run_start got CpuStart=%0b required 0", bus.CpuStart);
    end
  endtask

  task automatic ack_at(input int n);
    wait_run_start();
    repeat (n - 1) @(negedge clk);
    bus.CpuAck = 1'b1;
    @(negedge clk);
    bus.CpuAck = 1'b0;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (bus.Busy !== 1'b0 || bus.CpuReset !== 1'b1 || bus.CpuStart !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL %s got busy=%0b rst=%0b start=%0b pending=%0d required 0 1 0 0",
               name, bus.Busy, bus.CpuReset, bus.CpuStart, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Go = 1'b1;
    bus.ProgMask = 4'b0001;
    bus.Abort = 1'b0;
    bus.CpuAck = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.CpuReset !== 1'b1 || bus.CpuStart !== 1'b0 || bus.ProgSel !== 2'd0 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got rst=%0b start=%0b sel=%0d busy=%0b required 1 0 0 0",
               bus.CpuReset, bus.CpuStart, bus.ProgSel, bus.Busy);
    end
    total++;
    if (bus.Done !== 1'b0 || bus.ResultValid !== 1'b0 || bus.ResultProg !== 2'd0 ||
        bus.ResultCycles !== 16'd0 || bus.ResultTimeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_result got done=%0b rv=%0b rp=%0d rc=%0d rt=%0b required all 0",
               bus.Done, bus.ResultValid, bus.ResultProg, bus.ResultCycles, bus.ResultTimeout);
    end
    bus.Go = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_single();
    sb.push_back('{prog: 0, cycles: 5, tmo: 1'b0, done: 1'b1});
    go(4'b0001);
    total++;
    if (bus.CpuReset !== 1'b1 || bus.CpuStart !== 1'b1 || bus.Busy !== 1'b1 || bus.ProgSel !== 2'd0) begin
      bad++;
      $display("FAIL launch got rst=%0b start=%0b busy=%0b sel=%0d required 1 1 1 0",
               bus.CpuReset, bus.CpuStart, bus.Busy, bus.ProgSel);
    end
    @(negedge clk);
    total++;
    if (bus.CpuReset !== 1'b1) begin
      bad++;
      $display("FAIL init_len got CpuReset=%0b required 1", bus.CpuReset);
    end
    @(negedge clk);
    total++;
    if (bus.CpuReset !== 1'b0 || bus.CpuStart !== 1'b1) begin
      bad++;
      $display("FAIL start_phase got rst=%0b start=%0b required 0 1", bus.CpuReset, bus.CpuStart);
    end
    @(negedge clk);
    total++;
    if (bus.CpuStart !== 1'b1) begin
      bad++;
      $display("FAIL start_len got CpuStart=%0b required 1", bus.CpuStart);
    end
    @(negedge clk);
    total++;
    if (bus.CpuStart !== 1'b0 || bus.CpuReset !== 1'b0) begin
      bad++;
      $display("FAIL run_entry got rst=%0b start=%0b required 0 0", bus.CpuReset, bus.CpuStart);
    end
    ack_at(5);
    @(negedge clk);
    check_idle("single_end");
    total++;
    if (bus.ResultCycles !== 16'd5 || bus.ResultValid !== 1'b0) begin
      bad++;
      $display("FAIL result_hold got cyc=%0d rv=%0b required 5 0", bus.ResultCycles, bus.ResultValid);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{prog: 1, cycles: 3, tmo: 1'b0, done: 1'b0});
    sb.push_back('{prog: 3, cycles: 7, tmo: 1'b0, done: 1'b1});
    go(4'b1010);
    total++;
    if (bus.ProgSel !== 2'd1) begin
      bad++;
      $display("FAIL first_sel got %0d required 1", bus.ProgSel);
    end
    // Go while busy with a different mask must change nothing.
    bus.ProgMask = 4'b0101;
    bus.Go = 1'b1;
    @(negedge clk);
    bus.Go = 1'b0;
    ack_at(3);
    total++;
    if (bus.ProgSel !== 2'd3 || bus.CpuReset !== 1'b1 || bus.CpuStart !== 1'b1 || bus.Busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_reinit got sel=%0d rst=%0b start=%0b busy=%0b required 3 1 1 1",
               bus.ProgSel, bus.CpuReset, bus.CpuStart, bus.Busy);
    end
    ack_at(7);
    @(negedge clk);
    check_idle("b2b_end");
  endtask

  task automatic test_timeout();
    int n = 0;
    sb.push_back('{prog: 0, cycles: 100, tmo: 1'b1, done: 1'b0});
    sb.push_back('{prog: 1, cycles: 2, tmo: 1'b0, done: 1'b1});
    go(4'b0011);
    wait_run_start();
    while (bus.CpuStart === 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 100 || bus.ProgSel !== 2'd1) begin
      bad++;
      $display("FAIL watchdog_len got cycles=%0d sel=%0d required 100 1", n, bus.ProgSel);
    end
    ack_at(2);
    @(negedge clk);
    check_idle("timeout_end");
  endtask

  task automatic test_stale_ack();
    sb.push_back('{prog: 2, cycles: 1, tmo: 1'b0, done: 1'b1});
    bus.CpuAck = 1'b1;
    go(4'b0100);
    wait_run_start();
    @(negedge clk);
    bus.CpuAck = 1'b0;
    @(negedge clk);
    check_idle("stale_end");
  endtask

  task automatic test_abort();
    go(4'b0001);
    wait_run_start();
    repeat (9) @(negedge clk);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    check_idle("abort_next");
    repeat (20) @(negedge clk);
    check_idle("abort_quiet");
  endtask

  task automatic test_zero_mask();
    done_only = 1;
    go(4'b0000);
    total++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_mask_done got done=%0b busy=%0b required 1 0", bus.Done, bus.Busy);
    end
    @(negedge clk);
    total++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || done_only != 0) begin
      bad++;
      $display("FAIL zero_mask_after got done=%0b busy=%0b left=%0d required 0 0 0",
               bus.Done, bus.Busy, done_only);
    end
  endtask

  task automatic test_async_reset();
    go(4'b0001);
    wait_run_start();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.CpuReset !== 1'b1 || bus.CpuStart !== 1'b0 || bus.Busy !== 1'b0 || bus.ProgSel !== 2'd0) begin
      bad++;
      $display("FAIL async_reset got rst=%0b start=%0b busy=%0b sel=%0d required 1 0 0 0",
               bus.CpuReset, bus.CpuStart, bus.Busy, bus.ProgSel);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("async_after");
  endtask

  initial begin
    rst = 1'b1;
    bus.Go = 1'b0;
    bus.ProgMask = '0;
    bus.Abort = 1'b0;
    bus.CpuAck = 1'b0;
    test_reset();
    test_single();
    repeat (2) @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_timeout();
    repeat (2) @(negedge clk);
    test_stale_ack();
    repeat (2) @(negedge clk);
    test_abort();
    test_zero_mask();
    repeat (2) @(negedge clk);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_run_sequencer.md
# cpu_run_sequencer

Parametrised hardware run controller for the CPU core. It drives the CPU's reset/start launch sequence, waits for the CPU's completion acknowledge, and measures cycles-to-completion. It runs a batch of up to NUM_PROGS programs, selected by a mask, back to back, and applies a watchdog timeout per program. It sits between the system/bench control logic and the CPU's Reset/Start/Ack/program-select pins.

## Interface
- NUM_PROGS, 4: number of selectable programs; PSEL_W = max(1, clog2(NUM_PROGS)).
- CYC_W, 16: cycle counter width.
- INIT_CYCLES, 2: cycles CpuReset and CpuStart are held together; must be ≥1.
- START_CYCLES, 2: cycles CpuStart is held alone after CpuReset drops; must be ≥1.
- TIMEOUT, 1000: RUN cycles before a program is declared hung; 1 ≤ TIMEOUT ≤ 2^CYC_W-1.

- Clk  in  1  single clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high; forces every register to its reset value.
- Go  in  1  launch batch; sampled only in IDLE.
- ProgMask  in  NUM_PROGS  programs to run; latched on accepted Go.
- Abort  in  1  cancel batch; sampled in any non-IDLE state.
- CpuAck  in  1  CPU "program run complete".
- CpuReset  out  1  to CPU Reset.
- CpuStart  out  1  to CPU Start.
- ProgSel  out  PSEL_W  program index presented to CPU.
- Busy  out  1  batch in progress.
- Done  out  1  one-cycle pulse: batch finished.
- ResultValid  out  1  one-cycle pulse: per-program result valid.
- ResultProg  out  PSEL_W  program index of result.
- ResultCycles  out  CYC_W  RUN cycles consumed.
- ResultTimeout  out  1  result ended by watchdog, not CpuAck.

## Operation
- All outputs are registered.
- Reset values: CpuReset=1, CpuStart=0, ProgSel=0, Busy=0, Done=0, ResultValid=0, ResultProg=0, ResultCycles=0, ResultTimeout=0, state IDLE.
- IDLE: CpuReset=1, CpuStart=0, Busy=0. CpuReset stays asserted so the CPU is held quiescent.
  - Go=1 with ProgMask≠0: latch the mask, ProgSel = lowest set bit, enter INIT.
  - Go=1 with ProgMask=0: Done pulses on the next edge, Busy stays 0, no program is run.
- INIT: CpuReset=1, CpuStart=1, Busy=1. Lasts INIT_CYCLES cycles, then START.
- START: CpuReset=0, CpuStart=1. Lasts START_CYCLES cycles, then RUN with the counter cleared.
- RUN: CpuReset=0, CpuStart=0. The counter increments every RUN cycle.
  - CpuAck sampled high in RUN cycle n: ResultValid=1, ResultCycles=n, ResultTimeout=0, ResultProg=ProgSel.
  - n reaches TIMEOUT without CpuAck: ResultValid=1, ResultCycles=TIMEOUT, ResultTimeout=1.
- After any result:
  - If a higher mask bit is set, ProgSel = next set bit and the state re-enters INIT on the same edge.
  - Otherwise the state returns to IDLE on the same edge, Done=1 coincident with the final ResultValid, and Busy=0.
- CpuAck is ignored outside RUN. A stale Ack held from the previous program during INIT/START has no effect.
- Abort (non-IDLE states): next state IDLE, CpuReset=1, CpuStart=0, Busy=0. No ResultValid and no Done.
  - Abort has priority over CpuAck and timeout in the same cycle.
- Go is ignored while Busy. ProgMask changes after latching have no effect.
- Result* outputs hold their last values between pulses; only ResultValid and Done are pulses.

## Timing
- Go accepted at edge k: CpuReset=1, CpuStart=1, Busy=1 visible after edge k.
- CpuReset falls after edge k+INIT_CYCLES.
- CpuStart falls after edge k+INIT_CYCLES+START_CYCLES; that edge begins RUN cycle 1.
- CpuAck high during RUN cycle n: ResultValid visible for exactly one cycle after that cycle's edge.
- Minimum ResultCycles is 1, when Ack arrives in the first RUN cycle.
- Back-to-back programs: zero idle cycles between the result edge and the next INIT.
- Async Reset mid-batch: outputs take reset values immediately and the batch is lost. Release is synchronous to the next Clk edge.

## Test plan
- Assert Reset, clock 3 cycles → all outputs at reset values; Go ignored while Reset=1.
- ProgMask=4'b0001, Go pulse, CpuAck pulses in RUN cycle 5 → CpuReset high 2 cycles after Go, CpuStart high 4 cycles, ProgSel=0, ResultCycles=5, ResultTimeout=0, Done coincident with ResultValid, Busy=0 after.
- ProgMask=4'b1010, Ack at RUN cycle 3 then 7 → ProgSel 1 then 3; two ResultValid pulses (prog 1, 3 cycles; prog 3, 7 cycles); Done only with the second.
- TIMEOUT=100, ProgMask=4'b0011, no Ack for prog 0, Ack at cycle 2 for prog 1 → prog 0 result ResultCycles=100 with ResultTimeout=1, then prog 1 ResultCycles=2 with ResultTimeout=0.
- CpuAck held high through INIT/START → ignored; first RUN cycle yields ResultCycles=1.
- Abort in RUN cycle 10 → IDLE next cycle, CpuReset=1, no ResultValid/Done. Go with ProgMask=0 → Done pulse next cycle, Busy never 1.
